// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR frame sequencer: state encoding,
// default frame geometry, counter width and the DRAIN watchdog limit.
package fir_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } fir_seq_state_e;

    localparam int FRAME_LEN_DEF = 1024;
    localparam int TAPS_DEF      = 32;
    localparam int CNT_W         = 11;

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [7:0]       WDOG_LIMIT = 8'd255;

    // Counters stop at all-ones instead of wrapping back into a valid range.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 11'd1;
    endfunction

endpackage

// File: rtl/fir_seq_out_cnt.sv
// Result path: counts FIR strobes of the current frame, drops the warm-up and
// trailing results, and forwards the kept ones with their in-frame index.
module fir_seq_out_cnt
    import fir_seq_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int TAPS      = TAPS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        fir_valid,
    input  logic [15:0] fir_d,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [9:0]  out_idx,
    output logic        last_emit
);

    localparam logic [CNT_W-1:0] TAPS_C   = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] END_C    = CNT_W'(TAPS + FRAME_LEN);
    localparam logic [9:0]       LAST_IDX = 10'(FRAME_LEN - 1);

    logic [CNT_W-1:0] res_cnt_r;

    // Strobe counter and kept-result register, both cleared between frames.
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_cnt_r <= 11'd0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_idx   <= 10'd0;
        end else if (clr) begin
            res_cnt_r <= 11'd0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_idx   <= 10'd0;
        end else begin
            out_valid <= 1'b0;
            if (fir_valid) begin
                res_cnt_r <= cnt_sat_inc(res_cnt_r);
                if ((res_cnt_r >= TAPS_C) && (res_cnt_r < END_C)) begin
                    out_valid <= 1'b1;
                    out_data  <= fir_d;
                    out_idx   <= 10'(res_cnt_r - TAPS_C);
                end
            end
        end
    end

    assign last_emit = out_valid && (out_idx == LAST_IDX);

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR frame sequencer: clears the FIR, feeds one frame of samples plus a zero
// flush, and forwards the kept results. Optional DRAIN watchdog: FIR_SEQ_TIMEOUT_EN.
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int TAPS      = TAPS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        src_ready,
    output logic        fir_in_valid,
    output logic [15:0] fir_in_data,
    output logic        fir_clr,
    input  logic        fir_valid,
    input  logic [15:0] fir_d,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [9:0]  out_idx,
    output logic        frame_done,
    output logic        busy,
    output logic        err
);

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FRAME_LEN + TAPS - 1);

    fir_seq_state_e   state_r;
    fir_seq_state_e   state_s;
    logic [CNT_W-1:0] in_cnt_r;
    logic             push_s;
    logic             zero_s;
    logic             cancel_s;
    logic             start_ok_s;
    logic             timeout_s;
    logic             last_emit_s;
    logic             res_clr_s;

    assign cancel_s   = abort && (state_r != IDLE);
    assign start_ok_s = (state_r == IDLE) && start && !abort;
    assign res_clr_s  = (state_r == IDLE) || cancel_s || timeout_s;

`ifdef FIR_SEQ_TIMEOUT_EN
    logic [7:0] wd_r;

    // Watchdog: consecutive DRAIN cycles without a FIR result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_r <= 8'd0;
        end else if ((state_r != DRAIN) || fir_valid) begin
            wd_r <= 8'd0;
        end else if (wd_r != WDOG_LIMIT) begin
            wd_r <= wd_r + 8'd1;
        end else begin
            wd_r <= wd_r;
        end
    end

    assign timeout_s = (state_r == DRAIN) && (wd_r == WDOG_LIMIT);
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus this cycle's sample/zero push decision.
    always_comb begin
        state_s = state_r;
        push_s  = 1'b0;
        zero_s  = 1'b0;
        if (cancel_s || timeout_s) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        state_s = CLEAR;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CLEAR: begin
                    state_s = FEED;
                end
                FEED: begin
                    if (last_emit_s) begin
                        state_s = DONE;
                    end else if (src_valid) begin
                        push_s  = 1'b1;
                        state_s = (in_cnt_r == FEED_LAST) ? FLUSH : FEED;
                    end else begin
                        state_s = FEED;
                    end
                end
                FLUSH: begin
                    if (last_emit_s) begin
                        state_s = DONE;
                    end else begin
                        zero_s  = 1'b1;
                        state_s = (in_cnt_r == FLUSH_LAST) ? DRAIN : FLUSH;
                    end
                end
                DRAIN: begin
                    if (last_emit_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Registered outputs, input-side counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_cnt_r     <= 11'd0;
            src_ready    <= 1'b0;
            fir_in_valid <= 1'b0;
            fir_in_data  <= 16'h0000;
            fir_clr      <= 1'b1;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            src_ready    <= (state_s == FEED);
            busy         <= (state_s != IDLE);
            frame_done   <= (state_s == DONE);
            fir_clr      <= (state_s == CLEAR) || cancel_s;
            fir_in_valid <= push_s || zero_s;
            fir_in_data  <= push_s ? src_data : 16'h0000;

            if ((state_r == IDLE) || cancel_s || timeout_s) begin
                in_cnt_r <= 11'd0;
            end else if (push_s || zero_s) begin
                in_cnt_r <= cnt_sat_inc(in_cnt_r);
            end else begin
                in_cnt_r <= in_cnt_r;
            end

            // A fresh frame clears err; a stray result while idle sets it.
            if (start_ok_s) begin
                err <= 1'b0;
            end else if (((state_r == IDLE) && fir_valid) || timeout_s) begin
                err <= 1'b1;
            end else begin
                err <= err;
            end
        end
    end

    fir_seq_out_cnt #(
        .FRAME_LEN (FRAME_LEN),
        .TAPS      (TAPS)
    ) u_out_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (res_clr_s),
        .fir_valid (fir_valid),
        .fir_d     (fir_d),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .last_emit (last_emit_s)
    );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl (FRAME_LEN=8, TAPS=4) with a 3-cycle
// pass-through FIR stand-in, a count-based frame model and literal spot checks.
module tb_fir_seq_ctrl;

    localparam int FL = 8;
    localparam int TP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        src_valid = 1'b0;
    logic [15:0] src_data = 16'h0000;
    logic        src_ready, fir_in_valid, fir_clr, out_valid, frame_done, busy, err;
    logic [15:0] fir_in_data, out_data;
    logic [9:0]  out_idx;
    logic        fir_valid;
    logic [15:0] fir_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_seq_ctrl #(.FRAME_LEN(FL), .TAPS(TP)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .fir_in_valid(fir_in_valid), .fir_in_data(fir_in_data), .fir_clr(fir_clr),
        .fir_valid(fir_valid), .fir_d(fir_d),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .frame_done(frame_done), .busy(busy), .err(err)
    );

    // FIR stand-in: result = input + 0x1000 after 3 cycles; clear kills in-flight results.
    bit [2:0]    pv = 3'b000;
    logic [15:0] pd0 = 16'h0, pd1 = 16'h0, pd2 = 16'h0;
    bit          stall = 1'b0;
    bit          inj = 1'b0;
    always @(posedge clk) begin
        if (fir_clr) pv <= 3'b000;
        else         pv <= {pv[1:0], fir_in_valid && !stall};
        pd0 <= fir_in_data;
        pd1 <= pd0;
        pd2 <= pd1;
    end
    assign fir_valid = (pv[2] && !fir_clr) || inj;
    assign fir_d     = inj ? 16'hDEAD : (pd2 + 16'h1000);

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endfunction

    // Frame model: counts samples, zeros and results per frame.
    bit m_on = 0, m_busy = 0, m_clear = 0, m_done = 0, m_err = 0, prev_last = 0;
    int n_in = 0, n_z = 0, n_res = 0, wd = 0;
    logic e_src_ready = 1'b0, e_fiv = 1'b0, e_clr = 1'b0, e_ov = 1'b0, e_fd = 1'b0;
    logic e_busy = 1'b0, e_err = 1'b0;
    logic [15:0] e_fid = 16'h0, e_od = 16'h0;
    logic [9:0]  e_oi = 10'd0;

    always @(posedge clk) begin
        bit drain_now;
        bit go_idle;
        m_on = 1;
        prev_last = e_ov && (e_oi == 10'(FL - 1));
        e_fiv = 1'b0; e_fid = 16'h0; e_clr = 1'b0; e_ov = 1'b0; e_fd = 1'b0;
        if (!rst) begin
            m_busy = 0; m_clear = 0; m_done = 0; m_err = 0;
            n_in = 0; n_z = 0; n_res = 0; wd = 0;
            e_clr = 1'b1;
        end else if (!m_busy) begin
            if (start && !abort) begin
                m_busy = 1; m_clear = 1; m_err = 0;
                n_in = 0; n_z = 0; n_res = 0;
                e_clr = 1'b1;
            end else if (fir_valid) begin
                m_err = 1;
            end
        end else begin
            drain_now = !m_done && (n_in == FL) && (n_z == TP);
            go_idle = abort;
`ifdef FIR_SEQ_TIMEOUT_EN
            if (drain_now && wd == 255) begin
                go_idle = 1;
                m_err = 1;
            end
            if (drain_now && !fir_valid) wd = wd + 1;
            else wd = 0;
`endif
            if (go_idle) begin
                m_busy = 0; m_clear = 0; m_done = 0;
                n_in = 0; n_z = 0; n_res = 0;
                e_clr = abort;
            end else begin
                if (fir_valid) begin
                    if (n_res >= TP && n_res < TP + FL) begin
                        e_ov = 1'b1; e_od = fir_d; e_oi = 10'(n_res - TP);
                    end
                    n_res++;
                end
                if (m_done) begin
                    m_busy = 0; m_done = 0;
                end else if (prev_last) begin
                    m_done = 1; e_fd = 1'b1;
                end else if (m_clear) begin
                    m_clear = 0;
                end else if (n_in < FL) begin
                    if (src_valid) begin
                        e_fiv = 1'b1; e_fid = src_data; n_in++;
                    end
                end else if (n_z < TP) begin
                    e_fiv = 1'b1; n_z++;
                end
            end
        end
        e_busy = m_busy;
        e_err = m_err;
        e_src_ready = m_busy && !m_clear && !m_done && (n_in < FL);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            check("src_ready", 16'(src_ready), 16'(e_src_ready));
            check("fir_in_valid", 16'(fir_in_valid), 16'(e_fiv));
            check("fir_clr", 16'(fir_clr), 16'(e_clr));
            check("out_valid", 16'(out_valid), 16'(e_ov));
            check("frame_done", 16'(frame_done), 16'(e_fd));
            check("busy", 16'(busy), 16'(e_busy));
            check("err", 16'(err), 16'(e_err));
            if (e_fiv) check("fir_in_data", fir_in_data, e_fid);
            if (e_ov) begin
                check("out_data", out_data, e_od);
                check("out_idx", 16'(out_idx), 16'(e_oi));
            end
        end
    end

    // Event statistics for the hand-computed spot checks.
    int cyc = 0, st_cyc = 0, n_fd = 0, fd_cyc = 0, n_out = 0, n_fiv = 0, n_zero = 0, n_clr = 0;
    logic [15:0] first_out = 16'h0, last_out = 16'h0;
    always @(posedge clk) begin
        if (frame_done) begin n_fd++; fd_cyc = cyc; end
        if (out_valid) begin
            if (n_out == 0) first_out = out_data;
            last_out = out_data;
            n_out++;
        end
        if (fir_in_valid) begin
            n_fiv++;
            if (fir_in_data == 16'h0) n_zero++;
        end
        if (fir_clr) n_clr++;
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_fd = 0; n_out = 0; n_fiv = 0; n_zero = 0; n_clr = 0;
        first_out = 16'h0; last_out = 16'h0;
    endtask

    task automatic start_frame();
        st_cyc = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        int t;
        t = 0;
        src_valid = 1'b1;
        src_data = d;
        while (!src_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL send_wait got no src_ready expected src_ready within 50 cycles");
        end
        tick(1);
        src_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            tick(1);
            t++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle got busy=1 expected idle within %0d cycles", budget);
        end
    endtask

    task automatic run_frame(input logic [15:0] base, input bit gap);
        start_frame();
        for (int i = 1; i <= FL; i++) begin
            send(base + 16'(i));
            if (gap) tick(1);
        end
        check("ready_after_last", 16'(src_ready), 16'h0);
        wait_idle(200);
    endtask

    initial begin
        tick(3);
        check("rst_fir_clr", 16'(fir_clr), 16'h1);
        check("rst_busy", 16'(busy), 16'h0);
        rst = 1'b1;
        tick(2);
        check("idle_fir_clr", 16'(fir_clr), 16'h0);

        // start together with abort in IDLE resolves as abort
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        tick(1);
        check("start_abort_busy", 16'(busy), 16'h0);

        // back-to-back frame 1..8
        clear_stats();
        run_frame(16'h0000, 1'b0);
        check("s1_outs", 16'(n_out), 16'd8);
        check("s1_first_out", first_out, 16'h1005);
        check("s1_last_out", last_out, 16'h1000);
        check("s1_done_cnt", 16'(n_fd), 16'd1);
        check("s1_done_cycle", 16'(fd_cyc - st_cyc), 16'd19);
        check("s1_zeros", 16'(n_zero), 16'd4);
        check("s1_clr_cnt", 16'(n_clr), 16'd1);

        // src_valid toggling 1,0,1,0
        clear_stats();
        run_frame(16'h0020, 1'b1);
        check("s2_fir_in_cnt", 16'(n_fiv), 16'd12);
        check("s2_first_out", first_out, 16'h1025);
        check("s2_done_cnt", 16'(n_fd), 16'd1);

        // abort after sample 5, then a clean frame
        clear_stats();
        start_frame();
        for (int i = 1; i <= 5; i++) send(16'(i));
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", 16'(busy), 16'h0);
        check("abort_clr", 16'(fir_clr), 16'h1);
        tick(6);
        check("abort_no_done", 16'(n_fd), 16'd0);
        clear_stats();
        run_frame(16'h0000, 1'b0);
        check("s3_outs", 16'(n_out), 16'd8);
        check("s3_first_out", first_out, 16'h1005);
        check("s3_done_cnt", 16'(n_fd), 16'd1);

        // reset during FLUSH
        clear_stats();
        start_frame();
        for (int i = 1; i <= FL; i++) send(16'(i));
        rst = 1'b0;
        tick(1);
        check("s4_clr", 16'(fir_clr), 16'h1);
        check("s4_busy", 16'(busy), 16'h0);
        check("s4_fiv", 16'(fir_in_valid), 16'h0);
        check("s4_out_valid", 16'(out_valid), 16'h0);
        tick(1);
        rst = 1'b1;
        tick(2);
        check("s4_idle", 16'(busy), 16'h0);
        check("s4_no_done", 16'(n_fd), 16'd0);

        // stray FIR result in IDLE sets sticky err; next start clears it
        inj = 1'b1;
        tick(1);
        inj = 1'b0;
        tick(3);
        check("s5_err_set", 16'(err), 16'h1);
        start_frame();
        check("s5_err_clr", 16'(err), 16'h0);
        for (int i = 1; i <= FL; i++) send(16'(i));
        wait_idle(200);

`ifdef FIR_SEQ_TIMEOUT_EN
        // FIR stalls in DRAIN: watchdog aborts the frame
        clear_stats();
        stall = 1'b1;
        start_frame();
        for (int i = 1; i <= FL; i++) send(16'(i));
        wait_idle(400);
        check("s6_err", 16'(err), 16'h1);
        check("s6_no_done", 16'(n_fd), 16'd0);
        check("s6_no_out", 16'(n_out), 16'd0);
        stall = 1'b0;
`endif

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter FRAME_LEN, default 1024: samples per frame, power of two, range 8..1024.
REQ-003 Parameter TAPS, default 32: FIR tap count; zero-flush length and warm-up discard count.
REQ-004 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- start  in  1  one-cycle frame start request
- abort  in  1  one-cycle frame cancel
- src_valid  in  1  upstream sample valid
- src_data  in  16  upstream sample
- src_ready  out  1  upstream may transfer
- fir_in_valid  out  1  sample strobe to FIR
- fir_in_data  out  16  sample to FIR
- fir_clr  out  1  clears FIR tap registers
- fir_valid  in  1  FIR result strobe
- fir_d  in  16  FIR result
- out_valid  out  1  kept result strobe
- out_data  out  16  kept result
- out_idx  out  10  result index within frame
- frame_done  out  1  one-cycle end-of-frame pulse
- busy  out  1  high in any state except IDLE
- err  out  1  sticky error flag

Function
REQ-005 FSM states SHALL be IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
REQ-006 IDLE->CLEAR on start; start SHALL be ignored in all other states.
REQ-007 CLEAR SHALL last exactly one cycle with fir_clr=1, then go to FEED.
REQ-008 FEED: src_ready=1; each cycle with src_valid=1 SHALL register src_data to fir_in_data with fir_in_valid=1 on the next cycle and increment the input counter.
REQ-009 FEED->FLUSH on the cycle the FRAME_LEN-th sample is accepted; src_ready SHALL be 0 in all states other than FEED.
REQ-010 FLUSH: TAPS consecutive cycles with fir_in_valid=1 and fir_in_data=0, then go to DRAIN.
REQ-011 The result counter SHALL count fir_valid strobes from CLEAR onward; the first TAPS strobes SHALL be discarded, and the next FRAME_LEN strobes SHALL be forwarded one cycle later on out_valid/out_data with out_idx 0..FRAME_LEN-1; later strobes SHALL be discarded.
REQ-012 FEED, FLUSH or DRAIN SHALL go to DONE in the cycle after out_idx=FRAME_LEN-1 is emitted; DONE SHALL pulse frame_done for one cycle, then go to IDLE.
REQ-013 Counters SHALL be 11 bits wide, saturate at 2047, and never wrap.
REQ-014 abort in any state other than IDLE SHALL go to IDLE on the next cycle with a one-cycle fir_clr, no frame_done, and counters cleared; abort in IDLE SHALL be ignored.
REQ-015 abort and start in the same cycle SHALL resolve as abort.
REQ-016 fir_valid received in IDLE SHALL set err.
REQ-017 err SHALL clear only on reset or when a new start is accepted.

Reset
REQ-018 With rst=0 at a clock edge, the FSM SHALL return to IDLE from any state, including mid-frame.
REQ-019 With rst=0 at a clock edge, counters SHALL clear and all outputs SHALL go to 0, except fir_clr=1 for every reset cycle.

Configuration
REQ-020 With FIR_SEQ_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles in DRAIN without fir_valid; when it reaches 255 the block SHALL set err and go to IDLE without frame_done.
REQ-021 With FIR_SEQ_TIMEOUT_EN undefined, DRAIN SHALL wait indefinitely and no watchdog logic SHALL exist.

Structure
REQ-022 A shared package fir_seq_pkg SHALL hold the state enum, the default FRAME_LEN/TAPS constants and the watchdog limit.
REQ-023 The result-index/discard logic SHALL be a sub-module fir_seq_out_cnt.
REQ-024 The FSM and input path SHALL stay in fir_seq_ctrl.

Verification
All scenarios use FRAME_LEN=8 and TAPS=4, with a FIR model of fixed 3-cycle latency (one fir_valid per fir_in_valid).
REQ-025 Scenario: start, then 8 back-to-back samples 1..8 -> fir_clr for 1 cycle, then 8 fir_in_valid with data 1..8, then 4 zeros; out_idx 0..7; one frame_done; src_ready low after sample 8.
REQ-026 Scenario: src_valid toggling 1,0,1,0 -> accepted count tracks only valid cycles; fir_in_valid follows each accepted sample by exactly 1 cycle.
REQ-027 Scenario: abort after sample 5 -> IDLE next cycle, fir_clr pulse, no frame_done, busy=0; a new start then runs a full clean frame.
REQ-028 Scenario: rst=0 during FLUSH -> all outputs 0, fir_clr=1 during reset; IDLE after release.
REQ-029 Scenario: fir_valid injected in IDLE -> err=1; err stays 1 until the next start.
REQ-030 Scenario (FIR_SEQ_TIMEOUT_EN defined): FIR model stalls in DRAIN -> err=1 and IDLE after 255 cycles, no frame_done.
